// File: rtl/rpn_stack_ctrl_pkg.sv
// Shared constants and state encoding for the RPN stack controller and its ALU.
package rpn_stack_ctrl_pkg;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_END = 2'd3;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_OVF  = 2'd1;
   localparam logic [1:0] ERR_UNF  = 2'd2;

   typedef enum logic [3:0] {
      StIdle,
      StPush,
      StPopB,
      StWaitB,
      StPopA,
      StWaitA,
      StPopR,
      StWaitR,
      StErr
   } state_e;

endpackage

// File: rtl/rpn_alu.sv
// Combinational A/B/opcode arithmetic; every result wraps modulo 2^WIDTH.
module rpn_alu
   import rpn_stack_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_MUL:  result = a * b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// Evaluates an RPN token stream on an external LIFO; reports the result or a sticky stack error.
module rpn_stack_ctrl
   import rpn_stack_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tok_valid,
   output logic             tok_ready,
   input  logic             tok_is_op,
   input  logic [WIDTH-1:0] tok_data,
   input  logic             clr,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic [1:0]       err_code,
   output logic [WIDTH-1:0] lifo_in,
   output logic             lifo_wn,
   output logic             lifo_rn,
   input  logic [WIDTH-1:0] lifo_out,
   input  logic             lifo_full,
   input  logic             lifo_empty
);

   state_e           state_q, state_d;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] lifo_in_q;
   logic [WIDTH-1:0] res_data_q;
   logic             res_valid_q;
   logic [1:0]       err_q;
   logic [WIDTH-1:0] alu_res;
   logic             accept;

   assign accept = tok_valid && tok_ready;

   rpn_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a      (lifo_out),
      .b      (b_q),
      .op     (op_q),
      .result (alu_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (!tok_is_op) begin
                  state_d = lifo_full ? StErr : StPush;
               end else if (lifo_empty) begin
                  state_d = StErr;
               end else if (tok_data[1:0] == OP_END) begin
                  state_d = StPopR;
               end else begin
                  state_d = StPopB;
               end
            end
         end
         StPush:  state_d = StIdle;
         StPopB:  state_d = StWaitB;
         StWaitB: state_d = lifo_empty ? StErr : StPopA;
         StPopA:  state_d = StWaitA;
         StWaitA: state_d = StPush;
         StPopR:  state_d = StWaitR;
         StWaitR: state_d = StIdle;
         StErr:   state_d = clr ? StIdle : StErr;
         default: state_d = StIdle;
      endcase
   end

   // tok_ready is gated by rst_n so the source never sees a ready while reset is held.
   always_comb begin
      tok_ready = (state_q == StIdle) && rst_n;
      lifo_wn   = (state_q == StPush);
      lifo_rn   = (state_q == StPopB) || (state_q == StPopA) || (state_q == StPopR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q        <= OP_ADD;
         b_q         <= '0;
         lifo_in_q   <= '0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         err_q       <= ERR_NONE;
      end else begin
         res_valid_q <= 1'b0;
         if (state_q == StIdle && accept) begin
            op_q <= tok_data[1:0];
            if (!tok_is_op && !lifo_full) begin
               lifo_in_q <= tok_data;
            end
         end
         if (state_q == StWaitB) begin
            b_q <= lifo_out;
         end
         if (state_q == StWaitA) begin
            lifo_in_q <= alu_res;
         end
         if (state_q == StWaitR) begin
            res_data_q  <= lifo_out;
            res_valid_q <= 1'b1;
         end
         // Only an operand token can overflow; every other path into StErr is an underflow.
         if (state_q != StErr && state_d == StErr) begin
            err_q <= (state_q == StIdle && !tok_is_op) ? ERR_OVF : ERR_UNF;
         end else if (state_q == StErr && clr) begin
            err_q <= ERR_NONE;
         end
      end
   end

   assign lifo_in   = lifo_in_q;
   assign res_data  = res_data_q;
   assign res_valid = res_valid_q;
   assign err_code  = err_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Drives random and directed RPN token streams through rpn_stack_ctrl on an 8-deep LIFO.
module tb_rpn_stack_ctrl;

   localparam int Depth = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tok_valid = 1'b0;
   logic        tok_ready;
   logic        tok_is_op = 1'b0;
   logic [15:0] tok_data = '0;
   logic        clr = 1'b0;
   logic        res_valid;
   logic [15:0] res_data;
   logic [1:0]  err_code;
   logic [15:0] lifo_in;
   logic        lifo_wn;
   logic        lifo_rn;
   logic [15:0] lifo_out = '0;
   logic        lifo_full;
   logic        lifo_empty;

   int n_checks = 0;
   int n_errors = 0;

   rpn_stack_ctrl #(
      .WIDTH (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tok_valid  (tok_valid),
      .tok_ready  (tok_ready),
      .tok_is_op  (tok_is_op),
      .tok_data   (tok_data),
      .clr        (clr),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .err_code   (err_code),
      .lifo_in    (lifo_in),
      .lifo_wn    (lifo_wn),
      .lifo_rn    (lifo_rn),
      .lifo_out   (lifo_out),
      .lifo_full  (lifo_full),
      .lifo_empty (lifo_empty)
   );

   always #5 clk = ~clk;

   // Behavioural LIFO the controller talks to.
   logic [15:0] mem [Depth];
   logic [3:0]  cnt = '0;
   logic        lifo_clr = 1'b0;
   assign lifo_full  = (cnt == 4'(Depth));
   assign lifo_empty = (cnt == 4'd0);

   always @(posedge clk) begin
      if (lifo_clr) begin
         cnt <= '0;
      end else if (lifo_wn && cnt < 4'(Depth)) begin
         mem[cnt[2:0]] <= lifo_in;
         cnt <= cnt + 4'd1;
      end else if (lifo_rn && cnt > 4'd0) begin
         lifo_out <= mem[3'(cnt - 4'd1)];
         cnt <= cnt - 4'd1;
      end
   end

   int wn_cnt = 0;
   int rn_cnt = 0;
   bit both_seen = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (lifo_wn) wn_cnt++;
         if (lifo_rn) rn_cnt++;
         if (lifo_wn && lifo_rn) both_seen = 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: plain RPN evaluation on a queue, result wrapped to 16 bits.
   int          stk[$];
   logic [15:0] last_res;

   task automatic clear_all();
      lifo_clr = 1'b1;
      @(posedge clk); #1;
      lifo_clr = 1'b0;
      stk.delete();
   endtask

   task automatic do_token(input bit is_op, input logic [15:0] d);
      int  exp_err, exp_wn, exp_rn, k, lat, wn0, rn0, a, b, r;
      bit  exp_rv;
      longint t;
      exp_err = 0; exp_rv = 0; exp_wn = 0; exp_rn = 0; r = 0;
      if (!is_op) begin
         if (stk.size() == Depth) exp_err = 1;
         else begin stk.push_back(int'(d)); exp_wn = 1; end
      end else if (stk.size() == 0) begin
         exp_err = 2;
      end else if (d[1:0] == 2'd3) begin
         r = stk.pop_back(); exp_rv = 1; exp_rn = 1;
      end else if (stk.size() == 1) begin
         void'(stk.pop_back()); exp_err = 2; exp_rn = 1;
      end else begin
         b = stk.pop_back(); a = stk.pop_back();
         case (d[1:0])
            2'd0:    t = longint'(a) + longint'(b);
            2'd1:    t = longint'(a) - longint'(b) + 65536;
            default: t = longint'(a) * longint'(b);
         endcase
         stk.push_back(int'(t % 65536));
         exp_wn = 1; exp_rn = 2;
      end

      k = 0;
      while (!tok_ready && k < 20) begin @(posedge clk); #1; k++; end
      check("ready_before_token", {31'd0, tok_ready}, 1);
      wn0 = wn_cnt; rn0 = rn_cnt;
      tok_is_op = is_op; tok_data = d; tok_valid = 1'b1;
      @(posedge clk); #1;
      tok_valid = 1'b0;
      k = 1; lat = 0;
      while (!(tok_ready || err_code != 2'd0) && k < 20) begin
         if (lifo_wn && lat == 0) lat = k;
         @(posedge clk); #1;
         k++;
      end
      check("token_done_in_time", {31'd0, k < 20}, 1);
      check("err_code", {30'd0, err_code}, exp_err);
      check("res_valid", {31'd0, res_valid}, {31'd0, exp_rv});
      if (exp_rv) begin
         check("res_data", {16'd0, res_data}, r);
         last_res = res_data;
      end
      if (is_op && exp_wn == 1) check("op_wn_latency", lat, 5);
      if (exp_err != 0) begin
         tok_valid = 1'b1; tok_is_op = 1'b0;
         repeat (3) begin
            @(posedge clk); #1;
            check("err_not_ready", {31'd0, tok_ready}, 0);
         end
         tok_valid = 1'b0;
         check("err_held", {30'd0, err_code}, exp_err);
      end
      check("wn_pulses", wn_cnt - wn0, exp_wn);
      check("rn_pulses", rn_cnt - rn0, exp_rn);
      check("lifo_depth", {28'd0, cnt}, stk.size());
      if (cnt > 4'd0 && stk.size() > 0) check("lifo_top", {16'd0, mem[3'(cnt - 4'd1)]}, stk[$]);
      if (exp_err != 0) begin
         clr = 1'b1;
         @(posedge clk); #1;
         clr = 1'b0;
         check("clr_err", {30'd0, err_code}, 0);
         check("clr_ready", {31'd0, tok_ready}, 1);
         clear_all();
      end
   endtask

   task automatic operand(input logic [15:0] v);
      do_token(1'b0, v);
   endtask

   task automatic oper(input logic [1:0] op);
      do_token(1'b1, {14'd0, op});
   endtask

   initial begin
      int wn0, rn0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tok_ready", {31'd0, tok_ready}, 0);
      check("rst_res_valid", {31'd0, res_valid}, 0);
      check("rst_res_data", {16'd0, res_data}, 0);
      check("rst_err", {30'd0, err_code}, 0);
      check("rst_lifo_in", {16'd0, lifo_in}, 0);
      check("rst_strobes", {30'd0, lifo_wn, lifo_rn}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_ready", {31'd0, tok_ready}, 1);

      operand(3); operand(4); oper(2'd0); oper(2'd3);
      check("res_3_4_add", {16'd0, last_res}, 7);
      operand(10); operand(3); oper(2'd1); oper(2'd3);
      check("res_10_3_sub", {16'd0, last_res}, 7);
      operand(3); operand(10); oper(2'd1); oper(2'd3);
      check("res_3_10_sub", {16'd0, last_res}, 65529);
      operand(300); operand(300); oper(2'd2); oper(2'd3);
      check("res_300_300_mul", {16'd0, last_res}, 24464);
      check("empty_after_end", {31'd0, lifo_empty}, 1);

      oper(2'd0);
      operand(5); oper(2'd0);
      repeat (9) operand(16'(100 + $urandom_range(0, 50)));

      // Reset while the controller is in POP_A of "1 2 ADD".
      operand(1); operand(2);
      tok_is_op = 1'b1; tok_data = 16'd0; tok_valid = 1'b1;
      @(posedge clk); #1;
      tok_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check("pop_a_rn_before_reset", {31'd0, lifo_rn}, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_rn", {31'd0, lifo_rn}, 0);
      check("rst_mid_ready", {31'd0, tok_ready}, 0);
      check("rst_mid_lifo_in", {16'd0, lifo_in}, 0);
      repeat (2) begin @(posedge clk); #1; end
      check("rst_low_ready", {31'd0, tok_ready}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_release_ready", {31'd0, tok_ready}, 1);
      wn0 = wn_cnt; rn0 = rn_cnt;
      repeat (4) @(posedge clk);
      #1;
      check("rst_no_residual", (wn_cnt - wn0) + (rn_cnt - rn0), 0);
      clear_all();

      for (int i = 0; i < 300; i++) begin
         int sel;
         sel = $urandom_range(0, 99);
         if (sel < 55) begin
            if ($urandom_range(0, 1) == 0) operand(16'($urandom_range(0, 65535)));
            else operand(16'($urandom_range(0, 20)));
         end else if (sel < 90) begin
            oper(2'($urandom_range(0, 2)));
         end else begin
            oper(2'd3);
         end
      end

      check("wn_rn_exclusive", {31'd0, both_seen}, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
